// File: rtl/adc_decimator_pkg.sv
// Shared constants and types for the first-order sigma-delta decimator.
// Holds the OSR lookup, the osrSel encoding, the FSM state encoding and the
// default result width.
package adc_decimator_pkg;

    localparam int unsigned RESULT_WIDTH_DEF = 10;
    localparam int unsigned CNT_W            = 9;

    localparam int unsigned OSR_64  = 64;
    localparam int unsigned OSR_128 = 128;
    localparam int unsigned OSR_256 = 256;
    localparam int unsigned OSR_512 = 512;

    typedef enum logic [1:0] {
        OSR_SEL_64  = 2'd0,
        OSR_SEL_128 = 2'd1,
        OSR_SEL_256 = 2'd2,
        OSR_SEL_512 = 2'd3
    } osr_sel_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Counter value of the last sample in a window (OSR - 1).
    function automatic logic [CNT_W-1:0] osr_last(input logic [1:0] sel);
        logic [CNT_W-1:0] last;
        unique case (osr_sel_e'(sel))
            OSR_SEL_64:  last = CNT_W'(OSR_64 - 1);
            OSR_SEL_128: last = CNT_W'(OSR_128 - 1);
            OSR_SEL_256: last = CNT_W'(OSR_256 - 1);
            OSR_SEL_512: last = CNT_W'(OSR_512 - 1);
            default:     last = CNT_W'(OSR_64 - 1);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/adc_osr_counter.sv
// Window sample counter with terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return counter to zero (window aborted / not accumulating)
//   inc      : count one sample this cycle; wraps to 0 after terminal count
//   last     : counter value of the final sample of the window
//   tc_c     : combinational flag, current sample is the last of the window
module adc_osr_counter
    import adc_decimator_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] last,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    assign tc_c = (count == last);

    // Wrap on terminal count so windows run back-to-back.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_decimator.sv
// Sinc1 decimator: counts modulator ones over an OSR-sample window.
//   clk, rst     : clock, synchronous active-high reset
//   adcSample    : modulator bit, one per clk
//   enable       : accumulate when high; low aborts the current window
//   osrSel       : OSR select (64/128/256/512), latched at each window start
//   resultReady  : consumer accepts result this cycle
//   clearOverrun : clears the sticky overrun flag
//   result       : ones count of the last completed window
//   resultValid  : result holds unconsumed data
//   overrun      : sticky, an unconsumed result was overwritten
//   busy         : FSM is in ACCUM
module adc_decimator
    import adc_decimator_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH  = RESULT_WIDTH_DEF,
    parameter logic [1:0]  OSR_SEL_RESET = 2'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adcSample,
    input  logic                    enable,
    input  logic [1:0]              osrSel,
    input  logic                    resultReady,
    input  logic                    clearOverrun,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    resultValid,
    output logic                    overrun,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic [1:0]              osr_sel_q;
    logic [RESULT_WIDTH-1:0] acc;
    logic [RESULT_WIDTH-1:0] win_sum_c;
    logic                    cnt_clr, cnt_inc, osr_load, win_done, tc_c;

    adc_osr_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (osr_last(osr_sel_q)),
        .tc_c (tc_c)
    );

    // State register; busy mirrors the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_ACCUM);
        end
    end

    // Next state and window control.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b1;
        cnt_inc  = 1'b0;
        osr_load = 1'b0;
        win_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_ACCUM;
                    osr_load = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (enable) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                    if (tc_c) begin
                        win_done = 1'b1;
                        osr_load = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Final sample is folded in on the terminal cycle.
    assign win_sum_c = acc + RESULT_WIDTH'(adcSample);

    // Accumulator, result register and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            osr_sel_q   <= OSR_SEL_RESET;
            acc         <= '0;
            result      <= '0;
            resultValid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (osr_load) begin
                osr_sel_q <= osrSel;
            end
            if (!cnt_inc || win_done) begin
                acc <= '0;
            end else begin
                acc <= win_sum_c;
            end
            if (win_done) begin
                result <= win_sum_c;
            end
            if (win_done) begin
                resultValid <= 1'b1;
            end else if (resultReady) begin
                resultValid <= 1'b0;
            end
            // A new overrun takes priority over the clear.
            if (win_done && resultValid && !resultReady) begin
                overrun <= 1'b1;
            end else if (clearOverrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/adc_decimator.md
ADC_DECIMATOR -- requirements
Module: adc_decimator

Interface
REQ-001 Parameter RESULT_WIDTH, default 10, width of result; SHALL hold full-scale count 512.
REQ-002 Parameter OSR_SEL_RESET, default 2'd0, oversampling select applied after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 adcSample  input  1  registered modulator bit from upstream sampling flip-flop, one per clk.
REQ-006 enable  input  1  high = accumulate; low = idle, window aborted.
REQ-007 osrSel  input  2  oversampling ratio: 0=64, 1=128, 2=256, 3=512.
REQ-008 resultReady  input  1  consumer accepts result this cycle.
REQ-009 clearOverrun  input  1  clears sticky overrun flag.
REQ-010 result  output  RESULT_WIDTH  count of ones in last completed window, 0..OSR.
REQ-011 resultValid  output  1  result holds unconsumed data.
REQ-012 overrun  output  1  sticky: unconsumed result overwritten.
REQ-013 busy  output  1  high while in ACCUM state.

Function
REQ-014 FSM SHALL have states IDLE and ACCUM; IDLE->ACCUM on enable=1; ACCUM->IDLE on enable=0.
REQ-015 On IDLE->ACCUM and at every window start, osrSel SHALL be latched; changes mid-window SHALL be ignored.
REQ-016 In ACCUM, each cycle SHALL increment sample counter and add adcSample to accumulator.
REQ-017 On the cycle sample counter equals OSR-1, accumulator+adcSample SHALL load into result next edge; resultValid=1 on that edge (latency 1 clk after last window sample).
REQ-018 Windows SHALL be back-to-back: next window starts on the cycle after the last sample, no dropped samples.
REQ-019 Result SHALL be an unsigned, saturation-free count; all-ones window at OSR=512 SHALL give 512, all-zeros 0.
REQ-020 resultValid SHALL clear on a cycle with resultValid=1 and resultReady=1 unless a new result loads that same edge.
REQ-021 New result with resultValid=1 and resultReady=0 SHALL overwrite result and set overrun.
REQ-022 New result simultaneous with resultReady=1 SHALL load, keep resultValid=1, not set overrun.
REQ-023 overrun SHALL clear on clearOverrun=1 unless a new overrun occurs same edge (set wins).
REQ-024 enable=0 mid-window SHALL discard partial accumulator and counter; pending result, resultValid, overrun retained.
REQ-025 resultReady with resultValid=0 SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force IDLE, counter=0, accumulator=0, result=0, resultValid=0, overrun=0, busy=0, latched OSR=OSR_SEL_RESET.
REQ-027 Reset mid-window SHALL discard all window and pending-result state; first window after reset starts fresh on first enable=1 cycle.

Structure
REQ-028 Shared package SHALL hold OSR lookup constants (64/128/256/512), osrSel encoding, FSM state encoding, RESULT_WIDTH default.
REQ-029 Window sample counter with terminal-count flag SHALL be sub-module adc_osr_counter; accumulator, output register and handshake remain top-level.

Verification
REQ-030 osrSel=0, adcSample constant 1, enable=1, ready=1 -> result=64, resultValid pulse every 64 clks, first 65 clks after enable.
REQ-031 osrSel=3, adcSample alternating 1/0 -> result=256; all-zeros -> 0; all-ones -> 512.
REQ-032 osrSel=0, resultReady=0 for two windows -> second result overwrites, overrun=1; clearOverrun=1 -> overrun=0.
REQ-033 resultReady=1 on exact edge new result loads -> resultValid stays 1, overrun stays 0.
REQ-034 osrSel changed 0->1 at sample 10 of window -> that window still 64 samples, next window 128.
REQ-035 enable=0 at sample 30, then enable=1 -> no partial result; next result counts full new window; rst mid-window -> all outputs 0 next cycle.
